// File: rtl/mux_rr_sched.sv
// Round-robin scheduler: four valid-qualified lanes share one DATA_W output channel, with a per-owner burst limit.
// Latency: grant is combinational in the consuming cycle; dataOut/validOut/laneOut are registered one cycle later.
// Backpressure: none downstream; a lane holds validIn high until it sees its grant. Stats macro: MUX_SCHED_STATS_EN (adds txCount).
module mux_rr_sched #(
    parameter int DATA_W = 8,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn0,
    input  logic [DATA_W-1:0] dataIn1,
    input  logic [DATA_W-1:0] dataIn2,
    input  logic [DATA_W-1:0] dataIn3,
    input  logic              validIn0,
    input  logic              validIn1,
    input  logic              validIn2,
    input  logic              validIn3,
    output logic              grant0,
    output logic              grant1,
    output logic              grant2,
    output logic              grant3,
    output logic [DATA_W-1:0] dataOut,
    output logic              validOut,
    output logic [1:0]        laneOut
`ifdef MUX_SCHED_STATS_EN
    ,
    output logic [15:0]       txCount
`endif
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            stateQ;
    logic [1:0]        ownerQ;
    logic [3:0]        cntQ;
    logic [1:0]        ptrQ;

    logic [3:0]        reqVec;
    logic [3:0]        othersVec;
    logic [2:0]        pickPtr;
    logic [2:0]        pickNext;
    logic              grantVld;
    logic [1:0]        grantIdx;
    logic [3:0]        cntNext;
    logic              goIdle;
    logic [3:0]        grantVec;
    logic [DATA_W-1:0] selData;

    // Returns {found, lane}: first requesting lane in the order start, start+1, ... mod 4.
    function automatic logic [2:0] rrPick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] lane;
        res = 3'b000;
        // Walk backwards so the earliest position in the search order is written last and wins.
        for (int k = 3; k >= 0; k--) begin
            lane = start + 2'(k);
            if (req[lane]) begin
                res = {1'b1, lane};
            end
        end
        return res;
    endfunction

    assign reqVec    = {validIn3, validIn2, validIn1, validIn0};
    assign othersVec = reqVec & ~(4'b0001 << ownerQ);
    assign pickPtr   = rrPick(reqVec, ptrQ);
    assign pickNext  = rrPick(othersVec, ownerQ + 2'd1);

    // Grant decision for this cycle: burst continuation, hand-over, sole-requester renewal, or release to IDLE.
    always_comb begin
        grantVld = 1'b0;
        grantIdx = ownerQ;
        cntNext  = cntQ;
        goIdle   = 1'b0;
        if (reset) begin
            case (stateQ)
                IDLE: begin
                    if (pickPtr[2]) begin
                        grantVld = 1'b1;
                        grantIdx = pickPtr[1:0];
                        cntNext  = 4'd1;
                    end
                end
                OWN: begin
                    if (reqVec[ownerQ] && (cntQ < 4'(BURST))) begin
                        grantVld = 1'b1;
                        grantIdx = ownerQ;
                        cntNext  = cntQ + 4'd1;
                    end else if (pickNext[2]) begin
                        grantVld = 1'b1;
                        grantIdx = pickNext[1:0];
                        cntNext  = 4'd1;
                    end else if (reqVec[ownerQ]) begin
                        // Uncontended owner keeps the channel; the burst window restarts.
                        grantVld = 1'b1;
                        grantIdx = ownerQ;
                        cntNext  = 4'd1;
                    end else begin
                        goIdle = 1'b1;
                    end
                end
                default: begin
                    goIdle = 1'b1;
                end
            endcase
        end
    end

    assign grantVec = grantVld ? (4'b0001 << grantIdx) : 4'b0000;
    assign grant0   = grantVec[0];
    assign grant1   = grantVec[1];
    assign grant2   = grantVec[2];
    assign grant3   = grantVec[3];

    // Data mux for the granted lane.
    always_comb begin
        case (grantIdx)
            2'd0:    selData = dataIn0;
            2'd1:    selData = dataIn1;
            2'd2:    selData = dataIn2;
            default: selData = dataIn3;
        endcase
    end

    // Scheduler state and registered output stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ   <= IDLE;
            ownerQ   <= 2'd0;
            cntQ     <= 4'd0;
            ptrQ     <= 2'd0;
            dataOut  <= '0;
            validOut <= 1'b0;
            laneOut  <= 2'd0;
        end else begin
            validOut <= grantVld;
            if (grantVld) begin
                dataOut <= selData;
                laneOut <= grantIdx;
                stateQ  <= OWN;
                ownerQ  <= grantIdx;
                cntQ    <= cntNext;
            end else if (goIdle) begin
                // Next search after an idle gap starts just past the last owner.
                stateQ <= IDLE;
                ptrQ   <= ownerQ + 2'd1;
                cntQ   <= 4'd0;
            end
        end
    end

`ifdef MUX_SCHED_STATS_EN
    // Saturating count of cycles that delivered a word on the output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            txCount <= 16'd0;
        end else if (validOut && (txCount != 16'hFFFF)) begin
            txCount <= txCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_sched.sv
module tb_mux_rr_sched;

    localparam int DATA_W = 8;
    localparam int BURST  = 4;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic [DATA_W-1:0] dIn [4];
    logic [3:0]       vIn = 4'b0000;
    logic             grant0, grant1, grant2, grant3;
    logic [DATA_W-1:0] dataOut;
    logic             validOut;
    logic [1:0]       laneOut;
    logic [3:0]       gVec;
`ifdef MUX_SCHED_STATS_EN
    logic [15:0]      txCount;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: owner/run-length view of the schedule plus expected registered outputs.
    bit          mHave = 0;
    int          mOwner = 0;
    int          mRun = 0;
    int          mPtr = 0;
    bit          expValid = 0;
    logic [7:0]  expData = 8'h00;
    logic [1:0]  expLane = 2'd0;
    logic [15:0] expTx = 16'd0;

    always #5 clk = ~clk;

    assign gVec = {grant3, grant2, grant1, grant0};

    mux_rr_sched #(.DATA_W(DATA_W), .BURST(BURST)) dut (
        .clk      (clk),
        .reset    (rstN),
        .dataIn0  (dIn[0]),
        .dataIn1  (dIn[1]),
        .dataIn2  (dIn[2]),
        .dataIn3  (dIn[3]),
        .validIn0 (vIn[0]),
        .validIn1 (vIn[1]),
        .validIn2 (vIn[2]),
        .validIn3 (vIn[3]),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant2   (grant2),
        .grant3   (grant3),
        .dataOut  (dataOut),
        .validOut (validOut),
        .laneOut  (laneOut)
`ifdef MUX_SCHED_STATS_EN
        ,
        .txCount  (txCount)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane the rules say should win this cycle, or -1 for no grant.
    function automatic int modelPick(input bit [3:0] v);
        bit [3:0] ownBit;
        int start;
        int lane;
        if (v == 4'b0000) return -1;
        if (mHave) begin
            ownBit = 4'b0001 << mOwner;
            if (v[mOwner] && ((mRun < BURST) || (v == ownBit))) return mOwner;
            start = (mOwner + 1) % 4;
        end else begin
            start = mPtr;
        end
        for (int k = 0; k < 4; k++) begin
            lane = (start + k) % 4;
            if (v[lane]) return lane;
        end
        return -1;
    endfunction

    // One clock: drive at negedge, check against the model, advance the model at posedge.
    task automatic doCycle(input bit rst, input bit [3:0] v, output logic [3:0] gObs);
        int p;
        logic [3:0] expG;
        @(negedge clk);
        rstN = rst;
        vIn  = v;
        #1;
        p    = rst ? modelPick(v) : -1;
        expG = (p < 0) ? 4'b0000 : (4'b0001 << p);
        gObs = gVec;
        chk("grant", {28'd0, gVec}, {28'd0, expG});
        chk("onehot", {31'd0, $onehot0(gVec)}, 32'd1);
        chk("grantOnValid", {28'd0, gVec & ~v}, 32'd0);
        chk("validOut", {31'd0, validOut}, {31'd0, expValid});
        chk("dataOut", {24'd0, dataOut}, {24'd0, expData});
        chk("laneOut", {30'd0, laneOut}, {30'd0, expLane});
`ifdef MUX_SCHED_STATS_EN
        chk("txCount", {16'd0, txCount}, {16'd0, expTx});
`endif
        @(posedge clk);
        if (!rst) expTx = 16'd0;
        else if (expValid && (expTx != 16'hFFFF)) expTx = expTx + 16'd1;
        if (!rst) begin
            expValid = 0; expData = 8'h00; expLane = 2'd0;
            mHave = 0; mPtr = 0; mRun = 0; mOwner = 0;
        end else begin
            expValid = (p >= 0);
            if (p >= 0) begin
                expData = dIn[p];
                expLane = p[1:0];
                if (mHave && (p == mOwner)) mRun = (mRun < BURST) ? mRun + 1 : 1;
                else mRun = 1;
                mOwner = p;
                mHave  = 1;
            end else if (mHave) begin
                mPtr  = (mOwner + 1) % 4;
                mHave = 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [3:0] g;
        bit   [3:0] v;
        int         density;
        for (int i = 0; i < 4; i++) dIn[i] = 8'h00;

        // Reset hold, then idle.
        for (int i = 0; i < 3; i++) doCycle(1'b0, 4'b0000, g);
        for (int i = 0; i < 5; i++) doCycle(1'b1, 4'b0000, g);
        chk("idleValidOut", {31'd0, validOut}, 32'd0);
        chk("idleDataOut", {24'd0, dataOut}, 32'd0);
        chk("idleLaneOut", {30'd0, laneOut}, 32'd0);

        // Sole requester ignores the burst limit.
        dIn[2] = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            doCycle(1'b1, 4'b0100, g);
            chk("soleGrant2", {28'd0, g}, 32'h4);
        end
        chk("soleValidOut", {31'd0, validOut}, 32'd1);
        chk("soleDataOut", {24'd0, dataOut}, 32'hA5);
        chk("soleLaneOut", {30'd0, laneOut}, 32'd2);

        // All lanes valid from a clean reset: BURST grants per lane in rotation.
        doCycle(1'b0, 4'b0000, g);
        for (int i = 0; i < 4; i++) dIn[i] = 8'h10 + 8'(i);
        for (int k = 0; k < 4 * 4 + 4; k++) begin
            doCycle(1'b1, 4'b1111, g);
            chk("rotGrant", {28'd0, g}, 32'd1 << ((k / BURST) % 4));
            chk("rotLaneOut", {30'd0, laneOut}, (k / BURST) % 4);
            chk("rotDataOut", {24'd0, dataOut}, 32'h10 + (k / BURST) % 4);
        end

        // Reset in the middle of a burst abandons ownership.
        doCycle(1'b0, 4'b1111, g);
        chk("rstGrantLow", {28'd0, g}, 32'd0);
        chk("rstValidOut", {31'd0, validOut}, 32'd0);
        chk("rstLaneOut", {30'd0, laneOut}, 32'd0);
`ifdef MUX_SCHED_STATS_EN
        chk("rstTxCount", {16'd0, txCount}, 32'd0);
`endif
        doCycle(1'b1, 4'b1111, g);
        chk("rstRestart0", {28'd0, g}, 32'd1);

        // Owner lane 1 drops at cnt=2 while lane 3 waits.
        doCycle(1'b0, 4'b0000, g);
        dIn[1] = 8'h3C; dIn[3] = 8'hC3;
        doCycle(1'b1, 4'b0010, g);
        doCycle(1'b1, 4'b0010, g);
        doCycle(1'b1, 4'b1000, g);
        chk("handoverGrant3", {28'd0, g}, 32'h8);
        chk("handoverLaneOut", {30'd0, laneOut}, 32'd3);
        chk("handoverDataOut", {24'd0, dataOut}, 32'hC3);

        // Lane 3 owns, requests vanish, then lanes 0 and 3 together: pointer wrapped to 0.
        for (int i = 0; i < 3; i++) doCycle(1'b1, 4'b1000, g);
        doCycle(1'b1, 4'b0000, g);
        chk("gapGrant", {28'd0, g}, 32'd0);
        chk("gapValidOut", {31'd0, validOut}, 32'd0);
        doCycle(1'b1, 4'b1001, g);
        chk("wrapGrant0", {28'd0, g}, 32'd1);

        // Randomized traffic; pending lanes hold request and data until granted.
        v = 4'b0000;
        for (int c = 0; c < 1800; c++) begin
            density = (c < 600) ? 25 : ((c < 1200) ? 60 : 95);
            for (int i = 0; i < 4; i++) begin
                if (!v[i] || g[i]) begin
                    v[i]   = ($urandom_range(0, 99) < density);
                    dIn[i] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 299) == 0) doCycle(1'b0, v, g);
            else doCycle(1'b1, v, g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
